// File: rtl/gb_pkg.sv
// gb_pkg: shared ghostbus constants and the window index helper used by decoders and generators
package gb_pkg;
  localparam int GB_MISS_CNT_W = 16;
  function automatic logic [31:0] gb_chan_idx(input logic [31:0] addr, input logic [31:0] base, input int subaw);
    return (addr - base) >> subaw;
  endfunction
endpackage

// File: rtl/gb_decode.sv
// gb_decode: combinational upstream address to one-hot child window hit plus miss flag
module gb_decode
  import gb_pkg::*;
#(
  parameter int AW    = 12,
  parameter int SUBAW = 9,
  parameter int BASE  = 0,
  parameter int NCH   = 4
) (
  input  logic [AW-1:0]  addr,
  output logic [NCH-1:0] hit,
  output logic           miss
);
  logic [31:0] idx;
  logic        ge;
  assign idx = gb_chan_idx(32'(addr), 32'(BASE), SUBAW);
  assign ge  = 32'(addr) >= 32'(BASE);
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) hit[i] = ge && idx == 32'(i);
  end
  assign miss = ~|hit;
endmodule

// File: rtl/gb_fanout.sv
// gb_fanout: registered ghostbus interposer splitting one upstream port into NCH child windows
module gb_fanout
  import gb_pkg::*;
#(
  parameter int              AW        = 12,
  parameter int              DW        = 32,
  parameter int              NCH       = 4,
  parameter int              SUBAW     = 9,
  parameter int              BASE      = 0,
  parameter int              CHILD_LAT = 1,
  parameter logic [DW-1:0]   MISS_DATA = '0
) (
  input  logic                     gb_clk,
  input  logic                     gb_rst,
  input  logic [AW-1:0]            gb_addr,
  input  logic [DW-1:0]            gb_dout,
  input  logic                     gb_we,
  input  logic                     gb_re,
  output logic [DW-1:0]            gb_din,
  output logic                     gb_rvalid,
  output logic [AW-1:0]            ch_addr,
  output logic [DW-1:0]            ch_dout,
  output logic [NCH-1:0]           ch_we,
  output logic [NCH-1:0]           ch_re,
  input  logic [NCH*DW-1:0]        ch_din,
  output logic [GB_MISS_CNT_W-1:0] miss_cnt
);
  logic [NCH-1:0]           hit;
  logic                     miss;
  logic [AW-1:0]            ch_addr_d, ch_addr_q;
  logic [DW-1:0]            ch_dout_d, ch_dout_q;
  logic [NCH-1:0]           ch_we_d, ch_we_q, ch_re_d, ch_re_q;
  logic [CHILD_LAT:0][NCH:0] tag_d, tag_q;
  logic [DW-1:0]            rdata, gb_din_d, gb_din_q;
  logic                     gb_rvalid_d, gb_rvalid_q;
  logic [GB_MISS_CNT_W-1:0] miss_cnt_d, miss_cnt_q;

  gb_decode #(.AW(AW), .SUBAW(SUBAW), .BASE(BASE), .NCH(NCH)) u_decode (
    .addr(gb_addr),
    .hit (hit),
    .miss(miss)
  );

  // BASE is window aligned, so the low SUBAW bits are already window-relative
  always_comb begin
    ch_addr_d = AW'(gb_addr[SUBAW-1:0]);
    ch_dout_d = gb_dout;
    ch_we_d   = hit & {NCH{gb_we}};
    ch_re_d   = hit & {NCH{gb_re}};
    tag_d     = '0;
    tag_d[0]  = {gb_re, ch_re_d};
    for (int i = 1; i <= CHILD_LAT; i++) tag_d[i] = tag_q[i-1];
    rdata = MISS_DATA;
    for (int i = 0; i < NCH; i++) if (tag_q[CHILD_LAT][i]) rdata = ch_din[i*DW +: DW];
    gb_rvalid_d = tag_q[CHILD_LAT][NCH];
    gb_din_d    = gb_rvalid_d ? rdata : gb_din_q;
    miss_cnt_d  = ((gb_we | gb_re) && miss && miss_cnt_q != '1) ? miss_cnt_q + GB_MISS_CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      ch_addr_q   <= '0;
      ch_dout_q   <= '0;
      ch_we_q     <= '0;
      ch_re_q     <= '0;
      tag_q       <= '0;
      gb_din_q    <= '0;
      gb_rvalid_q <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      ch_addr_q   <= ch_addr_d;
      ch_dout_q   <= ch_dout_d;
      ch_we_q     <= ch_we_d;
      ch_re_q     <= ch_re_d;
      tag_q       <= tag_d;
      gb_din_q    <= gb_din_d;
      gb_rvalid_q <= gb_rvalid_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign ch_addr   = ch_addr_q;
  assign ch_dout   = ch_dout_q;
  assign ch_we     = ch_we_q;
  assign ch_re     = ch_re_q;
  assign gb_din    = gb_din_q;
  assign gb_rvalid = gb_rvalid_q;
  assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_gb_fanout.sv
// tb_gb_fanout: scoreboard bench; DUT a is a 4-way fanout with random traffic, DUT b an offset 2-way for misses and saturation
module tb_gb_fanout;
  localparam int          AW    = 12;
  localparam int          DW    = 32;
  localparam int          NCH   = 4;
  localparam int          LAT   = 1;
  localparam logic [31:0] MD_A  = 32'hDEAD_BEEF;
  localparam int          LAT_B = 3;
  localparam logic [31:0] MD_B  = 32'h0BAD_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_chk  = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  logic              a_rst = 1'b1, a_we = 1'b0, a_re = 1'b0;
  logic [AW-1:0]     a_addr = '0;
  logic [DW-1:0]     a_dout = '0, a_din, a_ch_dout;
  logic              a_rvalid;
  logic [AW-1:0]     a_ch_addr;
  logic [NCH-1:0]    a_ch_we, a_ch_re;
  logic [NCH*DW-1:0] a_ch_din;
  logic [15:0]       a_miss;

  gb_fanout #(.AW(AW), .DW(DW), .NCH(NCH), .SUBAW(9), .BASE(0), .CHILD_LAT(LAT), .MISS_DATA(MD_A)) dut_a (
    .gb_clk(clk), .gb_rst(a_rst), .gb_addr(a_addr), .gb_dout(a_dout), .gb_we(a_we), .gb_re(a_re),
    .gb_din(a_din), .gb_rvalid(a_rvalid), .ch_addr(a_ch_addr), .ch_dout(a_ch_dout),
    .ch_we(a_ch_we), .ch_re(a_ch_re), .ch_din(a_ch_din), .miss_cnt(a_miss)
  );

  logic          b_rst = 1'b1, b_we = 1'b0, b_re = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din, b_ch_dout;
  logic          b_rvalid;
  logic [AW-1:0] b_ch_addr;
  logic [1:0]    b_ch_we, b_ch_re;
  logic [63:0]   b_ch_din = {32'h2222_2222, 32'h1111_1111};
  logic [15:0]   b_miss;

  gb_fanout #(.AW(AW), .DW(DW), .NCH(2), .SUBAW(9), .BASE('h400), .CHILD_LAT(LAT_B), .MISS_DATA(MD_B)) dut_b (
    .gb_clk(clk), .gb_rst(b_rst), .gb_addr(b_addr), .gb_dout(32'h7777_7777), .gb_we(b_we), .gb_re(b_re),
    .gb_din(b_din), .gb_rvalid(b_rvalid), .ch_addr(b_ch_addr), .ch_dout(b_ch_dout),
    .ch_we(b_ch_we), .ch_re(b_ch_re), .ch_din(b_ch_din), .miss_cnt(b_miss)
  );

  // children of DUT a: 512-word memories answering one cycle after ch_re
  logic [31:0] cmem [0:2047];
  always @(posedge clk)
    for (int i = 0; i < NCH; i++) begin
      if (a_ch_re[i]) a_ch_din[i*DW +: DW] <= cmem[i*512 + int'(a_ch_addr[8:0])];
      if (a_ch_we[i]) cmem[i*512 + int'(a_ch_addr[8:0])] <= a_ch_dout;
    end

  // reference: one flat upstream address space, window map from plain arithmetic
  logic [31:0] ref_mem [0:2047];
  int a_miss_exp = 0;
  typedef struct { int cyc; logic [31:0] data; } rd_t;
  typedef struct { int cyc; logic [3:0] we, re; logic [11:0] addr; logic [31:0] dout; logic [15:0] miss; } rq_t;
  rd_t rdq[$];
  rq_t rqq[$];
  logic a_done = 1'b0, b_done = 1'b0;

  function automatic logic [31:0] init_word(int a);
    return 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_a(input logic we, input logic re, input logic [11:0] addr, input logic [31:0] dout);
    rq_t r;
    rd_t d;
    logic mapped;
    int ch;
    @(posedge clk); #1;
    a_we = we; a_re = re; a_addr = addr; a_dout = dout;
    mapped = addr < 12'h800;
    ch = int'(addr) / 512;
    if (re) begin
      d.cyc = cyc + LAT + 2;
      d.data = mapped ? ref_mem[addr[10:0]] : MD_A;
      rdq.push_back(d);
    end
    if (we && mapped) ref_mem[addr[10:0]] = dout;
    if ((we || re) && !mapped && a_miss_exp < 65535) a_miss_exp++;
    r.cyc = cyc + 1;
    r.we = (we && mapped) ? 4'(1 << ch) : 4'h0;
    r.re = (re && mapped) ? 4'(1 << ch) : 4'h0;
    r.addr = 12'(addr[8:0]);
    r.dout = dout;
    r.miss = 16'(a_miss_exp);
    rqq.push_back(r);
  endtask

  task automatic check_zero_a(string tag);
    chk({tag, "_din"}, a_din, 0);
    chk({tag, "_rvalid"}, a_rvalid, 0);
    chk({tag, "_ch_we"}, a_ch_we, 0);
    chk({tag, "_ch_re"}, a_ch_re, 0);
    chk({tag, "_ch_addr"}, a_ch_addr, 0);
    chk({tag, "_ch_dout"}, a_ch_dout, 0);
    chk({tag, "_miss"}, a_miss, 0);
  endtask

  rq_t mr;
  rd_t md;
  always @(negedge clk) begin
    if (rqq.size() > 0 && rqq[0].cyc == cyc) begin
      mr = rqq.pop_front();
      chk("a_ch_we", a_ch_we, mr.we);
      chk("a_ch_re", a_ch_re, mr.re);
      chk("a_ch_addr", a_ch_addr, mr.addr);
      chk("a_ch_dout", a_ch_dout, mr.dout);
      chk("a_miss_cnt", a_miss, mr.miss);
    end
    if (rdq.size() > 0 && rdq[0].cyc < cyc) begin
      chk("a_rvalid_missing", 0, 1);
      void'(rdq.pop_front());
    end
    if (a_rvalid) begin
      if (rdq.size() == 0) chk("a_rvalid_spurious", 1, 0);
      else begin
        md = rdq.pop_front();
        chk("a_rd_cycle", cyc, md.cyc);
        chk("a_rd_data", a_din, md.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      cmem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("a_reset");
    @(posedge clk); #1;
    a_rst = 1'b0;
    drive_a(1, 0, 12'h3FF, 32'hA5A5_A5A5);
    drive_a(1, 0, 12'h600, 32'h0000_1234);
    drive_a(0, 0, 12'h000, 32'h0);
    drive_a(0, 1, 12'h600, 32'h0);
    drive_a(0, 0, 12'h000, 32'h0);
    for (int i = 0; i < 4; i++) drive_a(0, 1, 12'(i * 'h200), 32'h0);
    drive_a(0, 1, 12'h900, 32'h0);
    drive_a(1, 1, 12'h2A0, 32'hCAFE_0001);
    drive_a(0, 1, 12'h2A0, 32'h0);
    for (int i = 0; i < 1500; i++)
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 'hAFF)), $urandom);
    // read in flight when reset hits must never return
    drive_a(0, 1, 12'h7AB, 32'hFFFF_0000);
    @(posedge clk); #1;
    a_rst = 1'b1; a_re = 1'b0; a_we = 1'b0;
    rdq.delete();
    a_miss_exp = 0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check_zero_a("a_midrst");
    end
    @(posedge clk); #1;
    a_rst = 1'b0;
    drive_a(0, 1, 12'h7AB, 32'h0);
    drive_a(0, 1, 12'h3FF, 32'h0);
    for (int i = 0; i < 200; i++)
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 'hFFF)), $urandom);
    repeat (LAT + 4) drive_a(0, 0, 12'h0, 32'h0);
    @(negedge clk);
    chk("a_rdq_drained", rdq.size(), 0);
    a_done = 1'b1;
  end

  int t0;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_reset_din", b_din, 0);
    chk("b_reset_miss", b_miss, 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_re = 1'b1; b_addr = 12'h100; t0 = cyc;
    @(posedge clk); #1;
    b_re = 1'b0; b_we = 1'b1; b_addr = 12'hC00;
    @(negedge clk);
    chk("b_miss_rd_ch_re", b_ch_re, 0);
    chk("b_miss_rd_ch_we", b_ch_we, 0);
    chk("b_miss_cnt1", b_miss, 1);
    @(posedge clk); #1;
    b_we = 1'b0;
    @(negedge clk);
    chk("b_miss_wr_ch_we", b_ch_we, 0);
    chk("b_miss_cnt2", b_miss, 2);
    while (!b_rvalid && cyc < t0 + 20) @(negedge clk);
    chk("b_miss_latency", cyc - t0, LAT_B + 2);
    chk("b_miss_data", b_din, MD_B);
    @(negedge clk);
    chk("b_rvalid_pulse", b_rvalid, 0);
    @(posedge clk); #1;
    b_re = 1'b1; b_addr = 12'h600; t0 = cyc;
    @(posedge clk); #1;
    b_re = 1'b0;
    @(negedge clk);
    chk("b_hit_ch_re", b_ch_re, 2'b10);
    chk("b_hit_ch_addr", b_ch_addr, 0);
    chk("b_hit_no_miss", b_miss, 2);
    while (!b_rvalid && cyc < t0 + 20) @(negedge clk);
    chk("b_hit_latency", cyc - t0, LAT_B + 2);
    chk("b_hit_data", b_din, 32'h2222_2222);
    @(posedge clk); #1;
    b_we = 1'b1; b_addr = 12'h000;
    repeat (65532) @(posedge clk);
    #1 b_we = 1'b0;
    @(negedge clk);
    chk("b_cnt_fffe", b_miss, 16'hFFFE);
    @(posedge clk); #1;
    b_re = 1'b1; b_addr = 12'hF00;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_cnt_sat", b_miss, 16'hFFFF);
    end
    b_re = 1'b0;
    b_done = 1'b1;
  end

  initial begin
    wait (a_done && b_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/gb_fanout.md
# gb_fanout

Parametrised ghostbus interposer that splits one upstream ghostbus port into NCH equal-size child windows. It sits in any hierarchy level between a parent's ghostbus and its submodule instances. Unlike the fixed two-way combinational decode it replaces, it registers the decode, adds an explicit read strobe with fixed-latency read-data return and a valid flag, and counts unmapped accesses.

## Interface
- AW, 12: upstream address width.
- DW, 32: data width.
- NCH, 4: number of child channels, 1..16.
- SUBAW, 9: child window address width; each window is 2**SUBAW words.
- BASE, 0: address of channel 0; channel i occupies BASE + i*2**SUBAW; must be aligned to 2**SUBAW.
- CHILD_LAT, 1: cycles from ch_re to valid ch_din at every child, 0..7.
- MISS_DATA, 0: value returned for reads that hit no channel.

- gb_clk  in  1  bus clock; all logic on rising edge.
- gb_rst  in  1  synchronous, active-high reset.
- gb_addr  in  AW  upstream word address.
- gb_dout  in  DW  upstream write data.
- gb_we  in  1  write strobe, one cycle per write.
- gb_re  in  1  read strobe, one cycle per read.
- gb_din  out  DW  read data to upstream.
- gb_rvalid  out  1  one-cycle pulse, gb_din valid.
- ch_addr  out  AW  window-relative address, shared by all channels; bits above SUBAW are zero.
- ch_dout  out  DW  write data, shared.
- ch_we  out  NCH  per-channel write strobe.
- ch_re  out  NCH  per-channel read strobe.
- ch_din  in  NCH*DW  child read data, channel i at [i*DW +: DW].
- miss_cnt  out  16  saturating count of unmapped accesses.

## Operation
- Decode: hit[i] = (gb_addr − BASE) >> SUBAW == i, for gb_addr ≥ BASE and i < NCH; at most one hit bit set. No bit set = miss.
- Request stage (registered): ch_addr, ch_dout, ch_we = hit & {NCH{gb_we}}, ch_re = hit & {NCH{gb_re}}.
- Read tag pipeline: shift register CHILD_LAT+1 deep carrying {valid, hit one-hot}; entry loaded when gb_re is sampled, miss reads included (valid=1, hit=0).
- Return stage (registered): when tag exits valid, gb_din <= ch_din of the tagged channel, or MISS_DATA if hit=0; gb_rvalid <= 1. Otherwise gb_din holds its value, gb_rvalid <= 0.
- gb_we and gb_re in the same cycle: both issued to the same channel; legal.
- Back-to-back reads every cycle are fully pipelined; no stall, no backpressure.
- miss_cnt increments by 1 per cycle in which (gb_we | gb_re) and no hit; saturates at 16'hFFFF.

## Timing
- Write: gb_we at cycle n -> ch_we[i] high at cycle n+1, for exactly one cycle.
- Read: gb_re at cycle n -> ch_re[i] at n+1 -> child data at n+1+CHILD_LAT -> gb_din/gb_rvalid at n+2+CHILD_LAT. Total read latency CHILD_LAT+2, constant for hits and misses.
- Reset: while gb_rst is high, all outputs are 0 one cycle after the sampled edge (gb_din = 0, gb_rvalid = 0, ch_we = ch_re = 0, ch_addr = ch_dout = 0, miss_cnt = 0), and the tag pipeline is cleared.
- Reads in flight when reset asserts are dropped; no gb_rvalid is produced for them.
- Strobes sampled during reset are ignored.

## Structure
- Package gb_pkg: GB_MISS_CNT_W = 16, and a function that computes the channel index from address, BASE and SUBAW, shared with the generator.
- Sub-module gb_decode: combinational address -> one-hot hit plus miss flag, parametrised by AW, SUBAW, BASE and NCH. Reused by generated interposers.
- Top-level block: request registers, tag shift register, return mux and counter.

## Test plan
- NCH=4, SUBAW=9, BASE=0: write 0xA5A5A5A5 at 0x3FF -> ch_we=4'b0010 one cycle later, ch_addr=0x1FF, ch_dout=0xA5A5A5A5.
- CHILD_LAT=1: read 0x600 with ch_din[3]=0x1234 -> ch_re=4'b1000 at n+1; gb_din=0x1234 and gb_rvalid=1 at n+3.
- Reads to 0x000, 0x200, 0x400 and 0x600 on consecutive cycles -> four consecutive gb_rvalid pulses with each channel's data, in order.
- BASE=0x400, NCH=2: read 0x100 and write 0xC00 -> no ch strobes, gb_din=MISS_DATA at the read latency, miss_cnt=2. Preload miss_cnt to 0xFFFE and apply 3 misses -> miss_cnt holds at 0xFFFF.
- Issue a read, then assert gb_rst at n+1 -> no gb_rvalid, all outputs 0. After release, a new read returns the correct data with the standard latency.
